wrr_arbiter_ptr: RTL and testbench

Weighted round-robin arbiter with a rotating priority pointer and a registered, handshaked grant. Successor to the fixed-priority WRR arbiter: lowest index no longer wins by default, and a grant is held until the consumer accepts it. Each grant consumes one credit. Credits reload per round or on demand. Sits in front of shared buses, memory ports and DMA channels.

---
 rtl/wrr_arbiter_ptr.sv | 157 +++++++++++++++
 tb/tb_wrr_arbiter_ptr.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wrr_arbiter_ptr.sv
`default_nettype none
// ============================================================================
//  Module      : wrr_arbiter_ptr
//  Description : Weighted round-robin arbiter with rotating priority pointer,
//                per-requester credit counters and a registered, handshaked
//                grant. Optional burst lock: define WRR_ARB_PTR_LOCK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module wrr_arbiter_ptr #(
    parameter int WIDTH        = 4,
    parameter int CREDIT_WIDTH = 4,
    parameter int TOTAL_WIDTH  = CREDIT_WIDTH * WIDTH,
    parameter int ID_WIDTH     = $clog2(WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [TOTAL_WIDTH-1:0] credits,
    input  logic                   credit_load,
    input  logic [WIDTH-1:0]       req,
    input  logic                   accept,
`ifdef WRR_ARB_PTR_LOCK_EN
    input  logic                   lock,
`endif
    output logic [WIDTH-1:0]       grant,
    output logic [ID_WIDTH-1:0]    grant_id,
    output logic                   grant_valid,
    output logic [WIDTH-1:0]       credit_avail
);

    localparam logic [0:0]          c_IDLE      = 1'b0;
    localparam logic [0:0]          c_GRANT     = 1'b1;
    localparam logic [ID_WIDTH:0]   c_WIDTH_EXT = (ID_WIDTH+1)'(WIDTH);
    localparam logic [ID_WIDTH-1:0] c_LAST      = ID_WIDTH'(WIDTH - 1);

    logic [0:0]              r_state;
    logic [0:0]              w_state_nxt;
    logic [ID_WIDTH-1:0]     r_gidx;
    logic [ID_WIDTH-1:0]     w_gidx_nxt;
    logic [ID_WIDTH-1:0]     r_ptr;
    logic [ID_WIDTH-1:0]     w_ptr_nxt;
    logic [CREDIT_WIDTH-1:0] r_credit [WIDTH];
    logic [CREDIT_WIDTH-1:0] w_cfg    [WIDTH];
    logic [WIDTH-1:0]        w_cfg_nz;
    logic [WIDTH-1:0]        w_elig;
    logic                    w_found;
    logic [ID_WIDTH-1:0]     w_pick;
    logic [ID_WIDTH:0]       w_sum;
    logic [ID_WIDTH-1:0]     w_cand;
    logic [CREDIT_WIDTH-1:0] w_cur_credit;
    logic [CREDIT_WIDTH-1:0] w_dec;
    logic [ID_WIDTH-1:0]     w_gidx_inc;
    logic                    w_round_reload;
    logic                    w_consume;
    logic                    w_reload_all;
    logic                    w_lock;

`ifdef WRR_ARB_PTR_LOCK_EN
    assign w_lock = lock;
`else
    assign w_lock = 1'b0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_field
            assign w_cfg[gi]        = credits[CREDIT_WIDTH*gi +: CREDIT_WIDTH];
            assign w_cfg_nz[gi]     = |w_cfg[gi];
            assign credit_avail[gi] = |r_credit[gi];
        end
    endgenerate

    assign w_elig         = req & credit_avail;
    assign w_cur_credit   = r_credit[r_gidx];
    assign w_dec          = (w_cur_credit == '0) ? '0 : w_cur_credit - 1'b1;
    assign w_gidx_inc     = (r_gidx == c_LAST) ? '0 : r_gidx + 1'b1;
    // Round reload only when nobody with credit is asking but a configured requester is.
    assign w_round_reload = (r_state == c_IDLE) && !(|w_elig) && (|(req & w_cfg_nz));
    assign w_consume      = (r_state == c_GRANT) && accept;
    assign w_reload_all   = rst || credit_load || w_round_reload;

    // First eligible requester at or above the pointer, wrapping modulo WIDTH.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_sum   = '0;
        w_cand  = '0;
        for (int k = 0; k < WIDTH; k++) begin
            w_sum  = {1'b0, r_ptr} + (ID_WIDTH+1)'(k);
            w_cand = (w_sum >= c_WIDTH_EXT) ? ID_WIDTH'(w_sum - c_WIDTH_EXT)
                                            : ID_WIDTH'(w_sum);
            if (!w_found && w_elig[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_reload_all) begin
            for (int i = 0; i < WIDTH; i++) begin
                r_credit[i] <= w_cfg[i];
            end
        end else if (w_consume) begin
            r_credit[r_gidx] <= w_dec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_gidx  <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gidx  <= w_gidx_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gidx_nxt  = r_gidx;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            c_IDLE: begin
                if (w_found) begin
                    w_state_nxt = c_GRANT;
                    w_gidx_nxt  = w_pick;
                end
            end
            c_GRANT: begin
                if (accept) begin
                    // A locked accept keeps the burst going; pointer moves only on release.
                    if (!w_lock) begin
                        w_state_nxt = c_IDLE;
                        w_ptr_nxt   = (w_dec != '0) ? r_gidx : w_gidx_inc;
                    end
                end else if (!req[r_gidx]) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        grant       = '0;
        grant_id    = '0;
        grant_valid = (r_state == c_GRANT);
        if (r_state == c_GRANT) begin
            grant[r_gidx] = 1'b1;
            grant_id      = r_gidx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wrr_arbiter_ptr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wrr_arbiter_ptr
//  Description : Directed and random checks of wrr_arbiter_ptr against an
//                integer reference model of the arbitration rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wrr_arbiter_ptr;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] credits;
    logic        credit_load;
    logic [3:0]  req;
    logic        accept;
    logic        lock;
    logic [3:0]  grant;
    logic [1:0]  grant_id;
    logic        grant_valid;
    logic [3:0]  credit_avail;

    int total = 0;
    int bad   = 0;
    string phase = "init";

    int m_cred[4];
    int m_ptr;
    int m_gid;
    bit m_busy;

    always #5 clk = ~clk;

    wrr_arbiter_ptr #(.WIDTH(4), .CREDIT_WIDTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .credits      (credits),
        .credit_load  (credit_load),
        .req          (req),
        .accept       (accept),
`ifdef WRR_ARB_PTR_LOCK_EN
        .lock         (lock),
`endif
        .grant        (grant),
        .grant_id     (grant_id),
        .grant_valid  (grant_valid),
        .credit_avail (credit_avail)
    );

    function automatic int cfg(int i);
        return int'((credits >> (4 * i)) & 16'hF);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    // Reference model: one call per rising edge using the inputs present at it.
    task automatic model_update();
        bit reload;
        bit consume;
        bit lk;
        int dec;
        int found;
        int c;
        reload  = 0;
        consume = 0;
        dec     = 0;
        found   = -1;
`ifdef WRR_ARB_PTR_LOCK_EN
        lk = lock;
`else
        lk = 0;
`endif
        if (rst) begin
            m_busy = 0;
            m_ptr  = 0;
            m_gid  = 0;
            for (int i = 0; i < 4; i++) m_cred[i] = cfg(i);
            return;
        end
        if (!m_busy) begin
            for (int k = 0; k < 4; k++) begin
                c = (m_ptr + k) % 4;
                if (found < 0 && req[c] && m_cred[c] != 0) found = c;
            end
            if (found >= 0) begin
                m_busy = 1;
                m_gid  = found;
            end else begin
                for (int i = 0; i < 4; i++) if (req[i] && cfg(i) != 0) reload = 1;
            end
        end else if (accept) begin
            consume = 1;
            dec = (m_cred[m_gid] > 0) ? m_cred[m_gid] - 1 : 0;
            if (!lk) begin
                m_busy = 0;
                m_ptr  = (dec != 0) ? m_gid : (m_gid + 1) % 4;
            end
        end else if (!req[m_gid]) begin
            m_busy = 0;
        end
        if (credit_load || reload) begin
            for (int i = 0; i < 4; i++) m_cred[i] = cfg(i);
        end else if (consume) begin
            m_cred[m_gid] = dec;
        end
    endtask

    task automatic check_outputs();
        logic [3:0] av;
        for (int i = 0; i < 4; i++) av[i] = (m_cred[i] != 0);
        chk("valid", 32'(grant_valid), 32'(m_busy));
        chk("grant_id", 32'(grant_id), m_busy ? 32'(m_gid) : 32'd0);
        chk("grant", 32'(grant), m_busy ? (32'd1 << m_gid) : 32'd0);
        chk("avail", 32'(credit_avail), 32'(av));
    endtask

    task automatic step(input logic [3:0] r, input logic a, input logic ld, input logic lk);
        req         = r;
        accept      = a;
        credit_load = ld;
        lock        = lk;
        @(posedge clk);
        model_update();
        #1;
        check_outputs();
    endtask

    task automatic do_reset(input logic [15:0] cr);
        credits = cr;
        rst     = 1'b1;
        step(4'b0000, 1'b0, 1'b0, 1'b0);
        rst     = 1'b0;
    endtask

    int ids[$];
    int exp1[9];
    int exp2[8];
    int cnt;

    initial begin
        rst = 1'b0; credits = 16'h2222; credit_load = 1'b0;
        req = 4'b0; accept = 1'b0; lock = 1'b0;
        m_busy = 0; m_ptr = 0; m_gid = 0;
        for (int i = 0; i < 4; i++) m_cred[i] = 0;
        #1;

        // 1: equal weights, full request, constant accept
        phase = "equal";
        do_reset(16'h2222);
        exp1 = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
        ids.delete();
        for (int s = 0; s < 20; s++) begin
            step(4'b1111, 1'b1, 1'b0, 1'b0);
            if (grant_valid) ids.push_back(int'(grant_id));
        end
        chk("count", 32'(ids.size() >= 9), 32'd1);
        for (int k = 0; k < 9 && k < ids.size(); k++) chk("seq", 32'(ids[k]), 32'(exp1[k]));

        // 2: skewed weights, sparse request, pointer wrap
        phase = "skew";
        do_reset(16'h1113);
        exp2 = '{0, 0, 0, 2, 0, 0, 0, 2};
        ids.delete();
        for (int s = 0; s < 18; s++) begin
            step(4'b0101, 1'b1, 1'b0, 1'b0);
            if (grant_valid) ids.push_back(int'(grant_id));
        end
        chk("count", 32'(ids.size() >= 8), 32'd1);
        for (int k = 0; k < 8 && k < ids.size(); k++) chk("seq", 32'(ids[k]), 32'(exp2[k]));

        // 3: grant held without accept, then withdrawn
        phase = "hold";
        do_reset(16'h2222);
        step(4'b1110, 1'b0, 1'b0, 1'b0);
        for (int s = 0; s < 5; s++) step(4'b1110, 1'b0, 1'b0, 1'b0);
        chk("held_id", 32'(grant_id), 32'd1);
        step(4'b1100, 1'b0, 1'b0, 1'b0);
        chk("dropped", 32'(grant_valid), 32'd0);
        step(4'b1100, 1'b0, 1'b0, 1'b0);
        chk("next_id", 32'(grant_id), 32'd2);

        // 4: credit_load beats a same-cycle decrement
        phase = "load";
        do_reset(16'h2224);
        for (int s = 0; s < 4; s++) step(4'b0001, 1'b1, 1'b0, 1'b0);
        step(4'b0001, 1'b0, 1'b0, 1'b0);
        step(4'b0001, 1'b1, 1'b1, 1'b0);
        cnt = 0;
        for (int s = 0; s < 8; s++) begin
            step(4'b0001, 1'b1, 1'b0, 1'b0);
            if (grant_valid) cnt++;
        end
        chk("grants", 32'(cnt), 32'd4);

        // 5: zero-weight requester never granted, never reloads
        phase = "zero";
        do_reset(16'h1101);
        step(4'b0001, 1'b1, 1'b0, 1'b0);
        step(4'b0001, 1'b1, 1'b0, 1'b0);
        for (int s = 0; s < 20; s++) step(4'b0010, 1'b1, 1'b0, 1'b0);
        chk("no_reload", 32'(credit_avail[0]), 32'd0);
        step(4'b0011, 1'b0, 1'b0, 1'b0);
        step(4'b0011, 1'b0, 1'b0, 1'b0);
        chk("r0_valid", 32'(grant_valid), 32'd1);
        chk("r0_id", 32'(grant_id), 32'd0);

        // 6: reset while granting
        phase = "rst";
        do_reset(16'h3333);
        step(4'b1111, 1'b1, 1'b0, 1'b0);
        step(4'b1111, 1'b1, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        step(4'b1111, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        chk("valid0", 32'(grant_valid), 32'd0);
        chk("avail", 32'(credit_avail), 32'hF);

`ifdef WRR_ARB_PTR_LOCK_EN
        phase = "lock";
        do_reset(16'h3334);
        step(4'b0001, 1'b0, 1'b0, 1'b0);
        for (int s = 0; s < 3; s++) begin
            step(4'b0001, 1'b1, 1'b0, 1'b1);
            chk("burst_id", 32'(grant_id), 32'd0);
            chk("burst_valid", 32'(grant_valid), 32'd1);
        end
        step(4'b0001, 1'b1, 1'b0, 1'b0);
        chk("drained", 32'(credit_avail[0]), 32'd0);
`endif

        // Random traffic against the model
        phase = "random";
        do_reset(16'h2131);
        for (int s = 0; s < 600; s++) begin
            if (s % 60 == 0) credits = 16'($urandom) & 16'h3333;
            rst = ($urandom_range(0, 79) == 0);
            step(4'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)));
            rst = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
